// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch (if) and data (dm) ports share one
// single-outstanding memory port with fixed read latency and fetch anti-starvation.
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [15:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [LAT_W-1:0]  r_lat;
  logic [STV_W-1:0]  r_starve;
  logic              r_wr;
  logic              r_mis;
  logic              r_mem_en;
  logic [15:0]       r_addr;
  logic [15:0]       r_wdata;
  logic              r_if_rvalid;
  logic [15:0]       r_if_rdata;
  logic              r_if_err;
  logic              r_dm_rvalid;
  logic [15:0]       r_dm_rdata;
  logic              r_dm_err;

  logic              w_if_gnt;
  logic              w_dm_gnt;
  logic              w_starved;
  logic              w_done;
  logic [15:0]       w_gnt_addr;
  logic [15:0]       w_rsp_data;
  logic              w_rsp_err;

  assign w_starved  = (r_starve == STV_W'(STARVE_MAX));
  assign w_done     = (r_state != IDLE) && (r_lat == '0);
  assign w_gnt_addr = w_dm_gnt ? dm_addr : if_addr;
  // Misaligned accesses never reach memory, so their response is synthesised here.
  assign w_rsp_data = (r_mis || r_wr) ? 16'h0000 : mem_rdata;
  assign w_rsp_err  = r_mis | mem_err;

  always_comb begin
    w_next   = r_state;
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          if (if_req && (!dm_req || w_starved)) begin
            w_if_gnt = 1'b1;
            w_next   = BUSY_IF;
          end else if (dm_req) begin
            w_dm_gnt = 1'b1;
            w_next   = BUSY_DM;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (w_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lat       <= '0;
      r_starve    <= '0;
      r_wr        <= 1'b0;
      r_mis       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 16'h0000;
      r_if_err    <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= 16'h0000;
      r_dm_err    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mem_en    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 16'h0000;
      r_if_err    <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= 16'h0000;
      r_dm_err    <= 1'b0;

      // Only a lost arbitration in IDLE counts; waiting behind a busy port does not.
      if (w_if_gnt) begin
        r_starve <= '0;
      end else if ((r_state == IDLE) && if_req && !w_starved) begin
        r_starve <= r_starve + STV_W'(1);
      end

      if (w_if_gnt || w_dm_gnt) begin
        r_wr     <= w_dm_gnt & dm_wr;
        r_addr   <= w_gnt_addr;
        r_wdata  <= w_dm_gnt ? dm_wdata : 16'h0000;
        r_mis    <= w_gnt_addr[0];
        r_mem_en <= ~w_gnt_addr[0];
        r_lat    <= LAT_W'(MEM_LAT);
      end else if ((r_state != IDLE) && (r_lat != '0)) begin
        r_lat <= r_lat - LAT_W'(1);
      end

      if (w_done) begin
        if (r_state == BUSY_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= w_rsp_data;
          r_if_err    <= w_rsp_err;
        end else begin
          r_dm_rvalid <= 1'b1;
          r_dm_rdata  <= w_rsp_data;
          r_dm_err    <= w_rsp_err;
        end
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign dm_gnt    = w_dm_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign dm_err    = r_dm_err;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_en & r_wr;
  assign mem_addr  = r_mem_en ? r_addr : 16'h0000;
  assign mem_wdata = r_mem_en ? r_wdata : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a negedge monitor compares memory strobes and
// responses against scoreboard queues filled when each grant is observed.
module tb_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [15:0] if_addr, if_rdata;
  logic        dm_req, dm_wr, dm_gnt, dm_rvalid, dm_err;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_wr, mem_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_t;

  rsp_t ifQ[$];
  rsp_t dmQ[$];
  mem_t memQ[$];
  bit   gntLog[$];
  int   gntCyc[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit monEn    = 1'b0;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] memFn(input logic [15:0] a);
    return (a == 16'h0004) ? 16'hBEEF : ((a ^ 16'h5A5A) + 16'h0101);
  endfunction

  function automatic logic errFn(input logic [15:0] a);
    return (a[15:12] == 4'hF);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: data is valid only in the cycle MEM_LAT after the strobe, garbage otherwise.
  int          memLat = -1;
  logic [15:0] memAddr = 16'h0000;
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      memLat  = MEM_LAT;
      memAddr = mem_addr;
    end else if (memLat >= 0) begin
      memLat--;
    end
    if (memLat == 0) begin
      mem_rdata = memFn(memAddr);
      mem_err   = errFn(memAddr);
    end else begin
      mem_rdata = 16'hDEAD;
      mem_err   = 1'b1;
    end
  end

  // Monitor: compare outputs first, then record what the grant seen this cycle must produce.
  always @(negedge clk) begin
    rsp_t r;
    mem_t m;
    if (monEn) begin
      checkOutput("gnt_onehot", 32'(if_gnt & dm_gnt), 32'd0);
      if (!rst_n) checkOutput("gnt_in_reset", {if_gnt, dm_gnt}, 32'd0);

      if (mem_en) begin
        if (memQ.size() == 0) checkOutput("mem_en_unexpected", 32'd1, 32'd0);
        else begin
          m = memQ.pop_front();
          checkOutput("mem_en_cycle", cyc, m.cyc);
          checkOutput("mem_wr", mem_wr, m.wr);
          checkOutput("mem_addr", mem_addr, m.addr);
          checkOutput("mem_wdata", mem_wdata, m.wdata);
        end
      end else begin
        checkOutput("mem_idle_zero", {mem_wr, mem_addr, mem_wdata}, 32'd0);
        if (memQ.size() != 0 && memQ[0].cyc < cyc) begin
          checkOutput("mem_en_missing", 32'd0, 32'd1);
          void'(memQ.pop_front());
        end
      end

      if (if_rvalid) begin
        if (ifQ.size() == 0) checkOutput("if_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          r = ifQ.pop_front();
          checkOutput("if_rvalid_cycle", cyc, r.cyc);
          checkOutput("if_rdata", if_rdata, r.data);
          checkOutput("if_err", if_err, r.err);
        end
      end else begin
        checkOutput("if_idle_zero", {if_rdata, if_err}, 32'd0);
        if (ifQ.size() != 0 && ifQ[0].cyc < cyc) begin
          checkOutput("if_rvalid_missing", 32'd0, 32'd1);
          void'(ifQ.pop_front());
        end
      end

      if (dm_rvalid) begin
        if (dmQ.size() == 0) checkOutput("dm_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          r = dmQ.pop_front();
          checkOutput("dm_rvalid_cycle", cyc, r.cyc);
          checkOutput("dm_rdata", dm_rdata, r.data);
          checkOutput("dm_err", dm_err, r.err);
        end
      end else begin
        checkOutput("dm_idle_zero", {dm_rdata, dm_err}, 32'd0);
        if (dmQ.size() != 0 && dmQ[0].cyc < cyc) begin
          checkOutput("dm_rvalid_missing", 32'd0, 32'd1);
          void'(dmQ.pop_front());
        end
      end

      if (if_gnt) begin
        r.cyc  = cyc + 2 + MEM_LAT;
        r.data = if_addr[0] ? 16'h0000 : memFn(if_addr);
        r.err  = if_addr[0] ? 1'b1 : errFn(if_addr);
        ifQ.push_back(r);
        if (!if_addr[0]) begin
          m.cyc = cyc + 1; m.wr = 1'b0; m.addr = if_addr; m.wdata = 16'h0000;
          memQ.push_back(m);
        end
        gntLog.push_back(1'b0);
        gntCyc.push_back(cyc);
      end
      if (dm_gnt) begin
        r.cyc  = cyc + 2 + MEM_LAT;
        r.data = (dm_addr[0] || dm_wr) ? 16'h0000 : memFn(dm_addr);
        r.err  = dm_addr[0] ? 1'b1 : errFn(dm_addr);
        dmQ.push_back(r);
        if (!dm_addr[0]) begin
          m.cyc = cyc + 1; m.wr = dm_wr; m.addr = dm_addr; m.wdata = dm_wdata;
          memQ.push_back(m);
        end
        gntLog.push_back(1'b1);
        gntCyc.push_back(cyc);
      end
    end
  end

  // Raise one request, wait (bounded) for its grant, then drop it in the following cycle.
  task automatic applyStimulus(input bit isDm, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata, output int gcyc);
    bit got = 1'b0;
    gcyc = -1;
    if (isDm) begin
      dm_req = 1'b1; dm_wr = wr; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (isDm ? dm_gnt : if_gnt) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    checkOutput("grant_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (isDm) begin
      dm_req = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0000; dm_wdata = 16'h0000;
    end else begin
      if_req = 1'b0; if_addr = 16'h0000;
    end
  endtask

  task automatic waitIdle();
    repeat (MEM_LAT + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, gIf, gDm, g;
    bit expOrder[8];
    expOrder = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; if_req = 1'b1; if_addr = 16'h0000;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0000; dm_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_if_gnt", if_gnt, 1'b0);
    checkOutput("rst_dm_gnt", dm_gnt, 1'b0);
    checkOutput("rst_mem_en", mem_en, 1'b0);
    checkOutput("rst_rvalids", {if_rvalid, dm_rvalid}, 32'd0);
    checkOutput("rst_rdata", {if_rdata, dm_rdata}, 32'd0);
    monEn = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single fetch, then data request queued behind it");
    t0 = cyc;
    applyStimulus(1'b0, 1'b0, 16'h0004, 16'h0000, gIf);
    checkOutput("fetch_gnt_cycle", gIf, t0);
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, gDm);
    checkOutput("busy_wait_gnt_cycle", gDm, gIf + MEM_LAT + 2);
    waitIdle();

    $display("[TB] write ack");
    t0 = cyc;
    applyStimulus(1'b1, 1'b1, 16'h0010, 16'h1234, g);
    checkOutput("write_gnt_cycle", g, t0);
    waitIdle();

    $display("[TB] misaligned fetch, error read, misaligned write");
    applyStimulus(1'b0, 1'b0, 16'h0003, 16'h0000, g);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 16'hF002, 16'h0000, g);
    waitIdle();
    applyStimulus(1'b1, 1'b1, 16'h0021, 16'h5555, g);
    waitIdle();

    $display("[TB] contention with both requests held");
    gntLog.delete();
    gntCyc.delete();
    if_req = 1'b1; if_addr = 16'h0100;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200;
    for (int i = 0; i < 100 && gntLog.size() < 8; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    checkOutput("contention_grants", gntLog.size(), 32'd8);
    for (int i = 0; i < 8 && i < gntLog.size(); i++) begin
      checkOutput($sformatf("grant_order_%0d", i), 32'(gntLog[i]), 32'(expOrder[i]));
      if (i > 0) checkOutput($sformatf("grant_spacing_%0d", i), gntCyc[i] - gntCyc[i-1], MEM_LAT + 2);
    end
    waitIdle();

    $display("[TB] reset in the middle of a data read");
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, g);
    @(posedge clk); #1;
    rst_n = 1'b0; dm_req = 1'b1; dm_addr = 16'h0030;
    dmQ.delete();
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset_hold_dm_gnt", dm_gnt, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    t0 = cyc;
    applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000, g);
    checkOutput("post_reset_gnt_cycle", g, t0);
    waitIdle();

    for (int i = 0; i < 40 && (ifQ.size() != 0 || dmQ.size() != 0 || memQ.size() != 0); i++)
      @(posedge clk);
    checkOutput("drain_if", ifQ.size(), 32'd0);
    checkOutput("drain_dm", dmQ.size(), 32'd0);
    checkOutput("drain_mem", memQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency in cycles (legal range 1..8).
REQ-002 Parameter STARVE_MAX, default 3: consecutive lost arbitrations after which fetch gets priority (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 if_req  input  1  fetch requester read request; held with if_addr until if_gnt.
REQ-006 if_addr  input  16  fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch response valid (one-cycle pulse).
REQ-009 if_rdata  output  16  fetch read data.
REQ-010 if_err  output  1  fetch access error, qualified by if_rvalid.
REQ-011 dm_req  input  1  data requester request; held with dm_wr, dm_addr and dm_wdata until dm_gnt.
REQ-012 dm_wr  input  1  1 = write, 0 = read.
REQ-013 dm_addr  input  16  data byte address.
REQ-014 dm_wdata  input  16  write data.
REQ-015 dm_gnt  output  1  data request accepted this cycle.
REQ-016 dm_rvalid  output  1  data response or write ack (one-cycle pulse).
REQ-017 dm_rdata  output  16  data read data; 0 for writes.
REQ-018 dm_err  output  1  data access error, qualified by dm_rvalid.
REQ-019 mem_en  output  1  memory access strobe (one-cycle pulse).
REQ-020 mem_wr  output  1  memory write select.
REQ-021 mem_addr  output  16  memory address.
REQ-022 mem_wdata  output  16  memory write data.
REQ-023 mem_rdata  input  16  memory read data, valid MEM_LAT cycles after mem_en.
REQ-024 mem_err  input  1  memory error, valid together with mem_rdata.

Function
REQ-025 The FSM SHALL have three states:
- IDLE
- BUSY_IF
- BUSY_DM
REQ-026 Grants SHALL be combinational, asserted only in IDLE, and at most one grant SHALL be asserted per cycle.
REQ-027 In IDLE, arbitration SHALL be:
- only one requester active: that requester is granted;
- both active: dm wins, unless starve_cnt == STARVE_MAX, in which case if wins.
REQ-028 starve_cnt SHALL:
- increment, saturating at STARVE_MAX, on each cycle if_req loses arbitration;
- clear to 0 when if_gnt is asserted;
- otherwise hold.
REQ-029 On a grant edge the arbiter SHALL register the request's addr, wr and wdata, then enter BUSY_IF or BUSY_DM.
REQ-030 mem_en SHALL pulse for exactly one cycle, in the cycle after the grant (G+1), driving the registered request fields on mem_wr, mem_addr and mem_wdata.
REQ-031 mem_wr, mem_addr and mem_wdata SHALL be 0 whenever mem_en is 0.
REQ-032 The arbiter SHALL sample mem_rdata and mem_err in cycle G+1+MEM_LAT, using a latency counter of width clog2(MEM_LAT+1).
REQ-033 The owning requester's rvalid SHALL pulse in cycle G+2+MEM_LAT with registered rdata and err; the FSM SHALL return to IDLE so that a new grant can occur in that same cycle.
REQ-034 For a write, dm_rvalid SHALL serve as the write ack, with dm_rdata = 0 and dm_err = sampled mem_err.
REQ-035 An address with addr[0] = 1 SHALL still be granted, SHALL NOT assert mem_en, and SHALL respond with identical timing, rdata = 0 and err = 1.
REQ-036 Outside an rvalid pulse, rvalid, rdata and err SHALL be 0.
REQ-037 Requests arriving while BUSY SHALL wait without a grant; an active if_req that is not granted because the arbiter is BUSY SHALL NOT increment starve_cnt.
REQ-038 Dropping a req after its grant SHALL NOT affect the in-flight access.

Reset
REQ-039 While rst_n = 0 at a clock edge, the arbiter SHALL set state = IDLE, starve_cnt = 0, latency counter = 0, and all registered outputs to 0.
REQ-040 Reset mid-access SHALL abort the access: no rvalid SHALL be produced for it, and no mem_en SHALL be asserted after the reset edge.
REQ-041 if_gnt and dm_gnt SHALL be 0 while rst_n = 0.

Verification
REQ-042 Single fetch, MEM_LAT = 2:
- stimulus: if_req with if_addr = 0x0004 at cycle 0, memory returns 0xBEEF;
- response: if_gnt at cycle 0, mem_en with mem_addr = 0x0004 at cycle 1, if_rvalid with if_rdata = 0xBEEF at cycle 4, next grant possible at cycle 4.
REQ-043 Contention:
- stimulus: if_req and dm_req held continuously, STARVE_MAX = 3;
- response: grant order dm, dm, dm, if, dm, dm, dm, if.
REQ-044 Write ack:
- stimulus: dm_req with dm_wr = 1, dm_addr = 0x0010, dm_wdata = 0x1234;
- response: mem_en with mem_wr = 1 and mem_wdata = 0x1234 at G+1, dm_rvalid with dm_rdata = 0 at G+4.
REQ-045 Misaligned:
- stimulus: if_addr = 0x0003;
- response: mem_en never asserted, if_rvalid with if_err = 1 and if_rdata = 0 at G+4.
REQ-046 Reset mid-op:
- stimulus: rst_n = 0 at G+2 of a dm read;
- response: dm_rvalid never pulses, FSM in IDLE, next dm_req granted in the first cycle after rst_n returns to 1.
